// File: rtl/chunk_collector.sv
// chunk_collector: ping-pong input buffer writer.
// Fills one bank while the processor reads the other.
module chunk_collector #(
  parameter int SAMPLE_SIZE      = 24,
  parameter int IO_BUFF_SIZE     = 64,
  parameter int IO_BUFF_PTR_BITS = $clog2(IO_BUFF_SIZE)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        sample_valid,
  input  logic [SAMPLE_SIZE-1:0]      sample_in,
  input  logic                        proc_busy,
  input  logic                        clear_overrun,
  output logic [IO_BUFF_PTR_BITS-1:0] input_buff_ptr,
  output logic                        input_buff_bank,
  output logic [SAMPLE_SIZE-1:0]      input_buff_sample,
  output logic                        input_buff_write_pulse,
  output logic                        chunk_pulse,
  output logic                        read_bank,
  output logic                        overrun,
  output logic [7:0]                  overrun_count
);

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  localparam logic [IO_BUFF_PTR_BITS-1:0] LAST_PTR =
    IO_BUFF_PTR_BITS'(IO_BUFF_SIZE - 1);

  state_t                      r_state;
  logic [IO_BUFF_PTR_BITS-1:0] r_wr_ptr;
  logic                        r_wr_bank;
  logic                        r_pend;
  logic                        r_pend_bank;

  logic [IO_BUFF_PTR_BITS-1:0] r_ptr;
  logic                        r_bank;
  logic [SAMPLE_SIZE-1:0]      r_sample;
  logic                        r_wpulse;
  logic                        r_cpulse;
  logic                        r_read_bank;
  logic                        r_overrun;
  logic [7:0]                  r_ovc;

  logic       w_accept;
  logic       w_last;
  logic       w_done;
  logic       w_drop;
  logic [7:0] w_ovc_inc;

  assign w_accept  = (r_state == S_FILL) && enable && sample_valid;
  assign w_last    = w_accept && (r_wr_ptr == LAST_PTR);
  assign w_done    = w_last && !proc_busy;
  assign w_drop    = w_last && proc_busy;
  assign w_ovc_inc = (r_ovc == 8'hFF) ? 8'hFF : r_ovc + 8'd1;

  // Write port, completion pipeline, overrun status and fill FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_wr_bank   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_bank <= 1'b0;
      r_ptr       <= '0;
      r_bank      <= 1'b0;
      r_sample    <= '0;
      r_wpulse    <= 1'b0;
      r_cpulse    <= 1'b0;
      r_read_bank <= 1'b1;
      r_overrun   <= 1'b0;
      r_ovc       <= 8'd0;
    end else begin
      r_wpulse <= w_accept;
      r_cpulse <= r_pend;
      r_pend   <= w_done;

      if (r_pend)
        r_read_bank <= r_pend_bank;

      if (w_accept) begin
        r_ptr    <= r_wr_ptr;
        r_bank   <= r_wr_bank;
        r_sample <= sample_in;
      end

      if (w_done) begin
        r_pend_bank <= r_wr_bank;
        r_wr_bank   <= ~r_wr_bank;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
        r_ovc     <= clear_overrun ? 8'd1 : w_ovc_inc;
      end else if (clear_overrun) begin
        r_overrun <= 1'b0;
        r_ovc     <= 8'd0;
      end

      unique case (r_state)
        S_IDLE: begin
          r_wr_ptr <= '0;
          if (enable)
            r_state <= S_FILL;
        end
        S_FILL: begin
          if (!enable) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
          end else if (w_accept) begin
            r_wr_ptr <= w_last ? '0 :
              r_wr_ptr + IO_BUFF_PTR_BITS'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_wr_ptr <= '0;
        end
      endcase
    end
  end

  assign input_buff_ptr         = r_ptr;
  assign input_buff_bank        = r_bank;
  assign input_buff_sample      = r_sample;
  assign input_buff_write_pulse = r_wpulse;
  assign chunk_pulse            = r_cpulse;
  assign read_bank              = r_read_bank;
  assign overrun                = r_overrun;
  assign overrun_count          = r_ovc;

endmodule

// File: tb/tb_chunk_collector.sv
// tb_chunk_collector: table vectors, directed corner
// sequences and random stimulus against a reference model.
module tb_chunk_collector;

  localparam int SS = 24;
  localparam int NB = 64;
  localparam int PB = $clog2(NB);

  logic          clk;
  logic          rst;
  logic          enable;
  logic          sample_valid;
  logic [SS-1:0] sample_in;
  logic          proc_busy;
  logic          clear_overrun;
  logic [PB-1:0] input_buff_ptr;
  logic          input_buff_bank;
  logic [SS-1:0] input_buff_sample;
  logic          input_buff_write_pulse;
  logic          chunk_pulse;
  logic          read_bank;
  logic          overrun;
  logic [7:0]    overrun_count;

  chunk_collector #(
    .SAMPLE_SIZE (SS),
    .IO_BUFF_SIZE(NB)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .enable                (enable),
    .sample_valid          (sample_valid),
    .sample_in             (sample_in),
    .proc_busy             (proc_busy),
    .clear_overrun         (clear_overrun),
    .input_buff_ptr        (input_buff_ptr),
    .input_buff_bank       (input_buff_bank),
    .input_buff_sample     (input_buff_sample),
    .input_buff_write_pulse(input_buff_write_pulse),
    .chunk_pulse           (chunk_pulse),
    .read_bank             (read_bank),
    .overrun               (overrun),
    .overrun_count         (overrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_cp    = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Reference model: chunk fill count, active bank and
  // outputs scheduled for the next visible cycle.
  bit          m_active;
  int          m_cnt;
  bit          m_bank;
  bit          m_ovr;
  int          m_ovc;
  bit          p_cp;
  bit          p_rb;
  bit          e_wp;
  int          e_ptr;
  bit          e_bank;
  logic [SS-1:0] e_smp;
  bit          e_cp;
  bit          e_rb;

  task automatic model_reset();
    m_active = 0; m_cnt = 0; m_bank = 0;
    m_ovr = 0; m_ovc = 0; p_cp = 0; p_rb = 0;
    e_wp = 0; e_ptr = 0; e_bank = 0; e_smp = '0;
    e_cp = 0; e_rb = 1;
  endtask

  task automatic model_step(input bit en, input bit sv,
                            input logic [SS-1:0] smp,
                            input bit busy, input bit clr);
    bit dropped;
    dropped = 0;
    e_cp = p_cp;
    if (p_cp) e_rb = p_rb;
    p_cp = 0;
    e_wp = m_active && en && sv;
    if (e_wp) begin
      e_ptr  = m_cnt;
      e_bank = m_bank;
      e_smp  = smp;
      m_cnt++;
      if (m_cnt == NB) begin
        m_cnt = 0;
        if (!busy) begin
          p_cp = 1;
          p_rb = m_bank;
          m_bank = !m_bank;
        end else begin
          dropped = 1;
        end
      end
    end
    if (dropped) begin
      m_ovr = 1;
      if (clr) m_ovc = 1;
      else if (m_ovc < 255) m_ovc++;
    end else if (clr) begin
      m_ovr = 0;
      m_ovc = 0;
    end
    if (!en) begin
      m_active = 0;
      m_cnt = 0;
    end else begin
      m_active = 1;
    end
  endtask

  task automatic cycle(input bit en, input bit sv,
                       input logic [SS-1:0] smp,
                       input bit busy, input bit clr);
    enable        = en;
    sample_valid  = sv;
    sample_in     = smp;
    proc_busy     = busy;
    clear_overrun = clr;
    model_step(en, sv, smp, busy, clr);
    @(posedge clk);
    @(negedge clk);
    chk("wpulse", input_buff_write_pulse, e_wp);
    chk("cpulse", chunk_pulse, e_cp);
    chk("read_bank", read_bank, e_rb);
    chk("overrun", overrun, m_ovr);
    chk("ovc", overrun_count, m_ovc);
    if (e_wp) begin
      chk("wptr", input_buff_ptr, e_ptr);
      chk("wbank", input_buff_bank, e_bank);
      chk("wdata", input_buff_sample, e_smp);
    end
    if (chunk_pulse) n_cp++;
  endtask

  task automatic do_reset();
    rst = 1;
    enable = 0; sample_valid = 0; sample_in = '0;
    proc_busy = 0; clear_overrun = 0;
    #1;
    chk("rst_ptr", input_buff_ptr, 0);
    chk("rst_bank", input_buff_bank, 0);
    chk("rst_data", input_buff_sample, 0);
    chk("rst_wp", input_buff_write_pulse, 0);
    chk("rst_cp", chunk_pulse, 0);
    chk("rst_rb", read_bank, 1);
    chk("rst_ovr", overrun, 0);
    chk("rst_ovc", overrun_count, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    n_cp = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, '0, 0, 0);
  endtask

  task automatic chunk(input int base, input bit busy);
    for (int i = 0; i < NB; i++)
      cycle(1, 1, SS'(base + i), busy, 0);
  endtask

  typedef struct {
    bit          en;
    bit          sv;
    logic [SS-1:0] smp;
    bit          wp;
    int          ptr;
    logic [SS-1:0] esmp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1, 1, 24'hAA, 0, 0, 24'h0};
    tbl[1] = '{1, 1, 24'h11, 1, 0, 24'h11};
    tbl[2] = '{1, 0, 24'h00, 0, 0, 24'h0};
    tbl[3] = '{1, 1, 24'h22, 1, 1, 24'h22};
    tbl[4] = '{0, 1, 24'h33, 0, 0, 24'h0};
    tbl[5] = '{1, 1, 24'h44, 0, 0, 24'h0};
    tbl[6] = '{1, 1, 24'h55, 1, 0, 24'h55};
    tbl[7] = '{1, 1, 24'h66, 1, 1, 24'h66};

    rst = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].en, tbl[i].sv, tbl[i].smp, 0, 0);
      chk("tbl_wp", input_buff_write_pulse, tbl[i].wp);
      if (tbl[i].wp) begin
        chk("tbl_ptr", input_buff_ptr, tbl[i].ptr);
        chk("tbl_data", input_buff_sample, tbl[i].esmp);
      end
    end

    // single chunk
    do_reset();
    idle(1);
    chunk(0, 0);
    chk("A_last_ptr", input_buff_ptr, 63);
    chk("A_last_bank", input_buff_bank, 0);
    chk("A_no_pulse_yet", chunk_pulse, 0);
    cycle(1, 0, '0, 0, 0);
    chk("A_pulse_n2", chunk_pulse, 1);
    idle(3);
    chk("A_pulses", n_cp, 1);
    chk("A_rb", read_bank, 0);

    // back-to-back across a boundary
    do_reset();
    idle(1);
    for (int i = 0; i < 2 * NB; i++) begin
      cycle(1, 1, SS'(i), 0, 0);
      if (i == NB) begin
        chk("B_65_wp", input_buff_write_pulse, 1);
        chk("B_65_ptr", input_buff_ptr, 0);
        chk("B_65_bank", input_buff_bank, 1);
        chk("B_65_rb", read_bank, 0);
      end
    end
    idle(3);
    chk("B_pulses", n_cp, 2);
    chk("B_rb", read_bank, 1);

    // dropped chunk
    do_reset();
    idle(1);
    chunk(100, 1);
    idle(3);
    chk("C_pulses", n_cp, 0);
    chk("C_rb", read_bank, 1);
    chk("C_ovr", overrun, 1);
    chk("C_ovc", overrun_count, 1);
    cycle(1, 1, 24'h5, 0, 0);
    chk("C_rew_ptr", input_buff_ptr, 0);
    chk("C_rew_bank", input_buff_bank, 0);
    for (int i = 1; i < NB; i++) cycle(1, 1, SS'(i), 0, 0);
    chk("C_rew_last", input_buff_bank, 0);
    idle(3);
    chk("C_pulses2", n_cp, 1);
    chk("C_rb2", read_bank, 0);

    // overrun saturation and clear
    do_reset();
    idle(1);
    for (int c = 0; c < 256; c++) chunk(c, 1);
    chk("D_sat", overrun_count, 255);
    chk("D_ovr", overrun, 1);
    cycle(1, 0, '0, 0, 1);
    chk("D_clr_ovr", overrun, 0);
    chk("D_clr_ovc", overrun_count, 0);
    chunk(7, 1);
    chk("D_one", overrun_count, 1);
    for (int i = 0; i < NB - 1; i++) cycle(1, 1, SS'(i), 0, 0);
    cycle(1, 1, 24'h77, 1, 1);
    chk("D_co_ovr", overrun, 1);
    chk("D_co_ovc", overrun_count, 1);
    chk("D_pulses", n_cp, 0);

    // enable drop discards partial chunk
    do_reset();
    idle(1);
    for (int i = 0; i < 10; i++) cycle(1, 1, SS'(i), 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 24'h9, 0, 0);
    idle(1);
    cycle(1, 1, 24'h300, 0, 0);
    chk("E_ptr", input_buff_ptr, 0);
    chk("E_bank", input_buff_bank, 0);
    for (int i = 1; i < NB; i++) cycle(1, 1, SS'(i), 0, 0);
    idle(3);
    chk("E_pulses", n_cp, 1);
    chk("E_rb", read_bank, 0);

    // async reset mid-chunk
    do_reset();
    idle(1);
    for (int i = 0; i < 40; i++) cycle(1, 1, SS'(i + 1), 0, 0);
    #2 rst = 1;
    #1;
    chk("F_ptr", input_buff_ptr, 0);
    chk("F_bank", input_buff_bank, 0);
    chk("F_data", input_buff_sample, 0);
    chk("F_wp", input_buff_write_pulse, 0);
    chk("F_cp", chunk_pulse, 0);
    chk("F_rb", read_bank, 1);
    @(negedge clk);
    rst = 0;
    model_reset();
    n_cp = 0;
    idle(2);
    chk("F_nopulse", n_cp, 0);
    cycle(1, 1, 24'h400, 0, 0);
    chk("F_new_ptr", input_buff_ptr, 0);
    chk("F_new_bank", input_buff_bank, 0);
    for (int i = 1; i < NB; i++) cycle(1, 1, SS'(i), 0, 0);
    idle(3);
    chk("F_pulses", n_cp, 1);

    // random traffic
    do_reset();
    begin
      bit busy_r;
      busy_r = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 99) < 4) busy_r = !busy_r;
        cycle($urandom_range(0, 999) < 995,
              $urandom_range(0, 99) < 80,
              SS'($urandom),
              busy_r,
              $urandom_range(0, 99) < 2);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/chunk_collector.md
# chunk_collector

Input-side writer for the block-processing path. Accepts a stream of `SAMPLE_SIZE`-bit samples and writes them sequentially into a two-bank (ping-pong) input buffer memory. When a bank holds `IO_BUFF_SIZE` samples, it pulses `chunk_pulse` so the downstream chunk processor can read that bank while the other bank fills. Sits between the ADC/serial front end and the input buffer RAM that the processor reads.

## Interface
- `SAMPLE_SIZE`, 24: sample width in bits.
- `IO_BUFF_SIZE`, 64: samples per chunk (per bank); power of two.
- `IO_BUFF_PTR_BITS`, `$clog2(IO_BUFF_SIZE)`: buffer index width.

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `enable`  in  1  collection enable.
- `sample_valid`  in  1  one-cycle strobe; `sample_in` is valid.
- `sample_in`  in  `SAMPLE_SIZE`  incoming sample.
- `proc_busy`  in  1  high while the processor is still working on the last chunk.
- `clear_overrun`  in  1  synchronous clear of the overrun status.
- `input_buff_ptr`  out  `IO_BUFF_PTR_BITS`  write index.
- `input_buff_bank`  out  1  write bank select.
- `input_buff_sample`  out  `SAMPLE_SIZE`  write data.
- `input_buff_write_pulse`  out  1  write enable, one cycle per sample.
- `chunk_pulse`  out  1  one-cycle pulse: bank `read_bank` holds a complete chunk.
- `read_bank`  out  1  bank the processor reads.
- `overrun`  out  1  sticky flag: a chunk was dropped.
- `overrun_count`  out  8  dropped-chunk count, saturates at 255.

## Operation
- Internal state: `wr_ptr`, `wr_bank`, FSM {IDLE, FILL}.
- IDLE: `wr_ptr`=0 and samples are ignored. Move to FILL when `enable`=1.
- FILL: each accepted sample (`sample_valid`=1 and `enable`=1) is registered to the write port. Then `wr_ptr` increments.
- `enable`=0 in FILL: return to IDLE next edge and set `wr_ptr`=0. The partial chunk is discarded and no `chunk_pulse` is issued. A write or chunk pulse already registered still appears on the outputs.
- Chunk completion: the accepted sample with `wr_ptr`=`IO_BUFF_SIZE-1`.
  - `wr_ptr` wraps to 0.
  - If `proc_busy`=0 in that cycle: `wr_bank` toggles and a chunk completion is scheduled (see Timing).
  - If `proc_busy`=1: the chunk is dropped. `wr_bank` is unchanged, so the same bank is overwritten. No `chunk_pulse` is issued and `read_bank` is unchanged. `overrun` is set and `overrun_count` increments, saturating at 255.
- Invariant: writes never target `read_bank` while `proc_busy`=1.
- `clear_overrun`: sets `overrun`=0 and `overrun_count`=0. If it coincides with a new drop, the drop wins: `overrun`=1, `overrun_count`=1.
- Samples are written unmodified; no width conversion.

## Timing
- Reset values: `input_buff_ptr`=0, `input_buff_bank`=0, `input_buff_sample`=0, `input_buff_write_pulse`=0, `chunk_pulse`=0, `read_bank`=1, `overrun`=0, `overrun_count`=0. Internal state: `wr_bank`=0, FSM=IDLE.
- Sample accepted in cycle N: the write port shows ptr/bank/sample with `input_buff_write_pulse`=1 in cycle N+1. Latency is 1 cycle.
- Chunk completion for a last sample accepted in cycle N:
  - The last write appears in N+1 with the old bank.
  - `chunk_pulse`=1 and `read_bank` = the completed bank in N+2, so the pulse follows the committed write.
- Throughput: one sample per cycle. Back-to-back `sample_valid` is allowed across a chunk boundary. A sample accepted in N+1 writes index 0 of the new bank in N+2.
- `proc_busy` is sampled only in the completion cycle N.
- Reset asserted mid-chunk: all registers return to reset values immediately. No pulse is issued after reset releases.
- `chunk_pulse` and `input_buff_write_pulse` are never wider than one cycle.

## Test plan
- Reset, `enable`=1, 64 consecutive samples 0..63 with `proc_busy`=0:
  - 64 writes to bank 0 with ptr 0..63 and data = index.
  - `chunk_pulse` exactly once, 2 cycles after the last `sample_valid`.
  - `read_bank` 1→0.
- 128 back-to-back samples: first chunk to bank 0 with `read_bank`=0. The 65th sample is written to bank 1 ptr 0 with no gap. Second `chunk_pulse` with `read_bank`=1.
- Drop case: fill bank 0 with `proc_busy`=1 held through completion:
  - no `chunk_pulse`; `read_bank` stays 1.
  - `overrun`=1, `overrun_count`=1.
  - The next 64 samples rewrite bank 0 ptr 0..63.
- Overrun status: 256 dropped chunks give `overrun_count`=255 (saturated). `clear_overrun` pulse gives 0/0. `clear_overrun` coincident with a drop gives `overrun`=1, count=1.
- `enable` deasserted after 10 samples, then reasserted with 64 samples: no `chunk_pulse` for the partial chunk. The new chunk starts at ptr 0, bank 0, and completes normally.
- Async `rst` pulse mid-cycle after 40 samples: outputs go to reset values without a clock edge. The subsequent full chunk writes bank 0 from ptr 0.
